sobel_window_gen: RTL and testbench

Streaming 3x3 window generator that sits immediately upstream of `sobel_calc_mod`. It accepts a raster-order grayscale pixel stream, buffers the two previous image lines, and presents each full 3x3 neighbourhood on `d0_o`..`d8_o` with a one-cycle `done_o` strobe. The outputs connect directly to `sobel_calc_mod`'s `d0_i`..`d8_i` and `done_i`. Border windows (first two rows and first two columns) are never emitted; there is no padding.

---
 rtl/sobel_pkg.sv | 14 +
 rtl/sobel_line_buf.sv | 28 ++
 rtl/sobel_window_gen.sv | 170 +++++++++++++++++
 tb/tb_sobel_window_gen.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared defaults and pixel/window types for the Sobel window generator.
package sobel_pkg;

    localparam int DEF_IMG_W = 640;
    localparam int DEF_IMG_H = 480;
    localparam int DEF_DW    = 8;

    localparam int DEF_COL_W = $clog2(DEF_IMG_W);
    localparam int DEF_ROW_W = $clog2(DEF_IMG_H);

    typedef logic [DEF_DW-1:0] pix_t;
    typedef pix_t              win_t [9];

endpackage

// File: rtl/sobel_line_buf.sv
// Single-line pixel memory: combinational read and synchronous write at the
// same address, so the read returns the value stored one line earlier.
module sobel_line_buf
    import sobel_pkg::*;
#(
    parameter int DEPTH = DEF_IMG_W,
    parameter int DW    = DEF_DW,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wr_data,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem_r [DEPTH];

    assign rd_data = mem_r[addr];

    // Store the incoming pixel; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator: two line buffers plus a 3x3 shift register,
// emitting one window per accepted pixel once row >= 2 and col >= 2.
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int DW    = DEF_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] pix_i,
    input  logic          done_i,
    input  logic          sof_i,
    output logic [DW-1:0] d0_o,
    output logic [DW-1:0] d1_o,
    output logic [DW-1:0] d2_o,
    output logic [DW-1:0] d3_o,
    output logic [DW-1:0] d4_o,
    output logic [DW-1:0] d5_o,
    output logic [DW-1:0] d6_o,
    output logic [DW-1:0] d7_o,
    output logic [DW-1:0] d8_o,
    output logic          done_o,
    output logic          eof_o
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0] col_r;
    logic [RW-1:0] row_r;
    logic [CW-1:0] cur_col_s;
    logic [RW-1:0] cur_row_s;
    logic [CW-1:0] nxt_col_s;
    logic [RW-1:0] nxt_row_s;
    logic [DW-1:0] lb0_rd_s;
    logic [DW-1:0] lb1_rd_s;
    logic          win_hit_s;
    logic          last_hit_s;
    logic [DW-1:0] win_r [9];
    logic          done_r;
    logic          eof_r;

    // Position of the pixel on the input: sof forces (0,0) over the counters.
    always_comb begin
        cur_col_s = col_r;
        cur_row_s = row_r;
        if (done_i && sof_i) begin
            cur_col_s = '0;
            cur_row_s = '0;
        end else begin
            cur_col_s = col_r;
            cur_row_s = row_r;
        end
    end

    // Raster advance from the current position, wrapping column then row.
    always_comb begin
        nxt_col_s = cur_col_s;
        nxt_row_s = cur_row_s;
        if (cur_col_s == COL_LAST) begin
            nxt_col_s = '0;
            if (cur_row_s == ROW_LAST) begin
                nxt_row_s = '0;
            end else begin
                nxt_row_s = cur_row_s + RW'(1);
            end
        end else begin
            nxt_col_s = cur_col_s + CW'(1);
            nxt_row_s = cur_row_s;
        end
    end

    // Border windows hold stale or wrapped data, so only interior positions emit.
    assign win_hit_s  = (cur_row_s >= RW'(2)) && (cur_col_s >= CW'(2));
    assign last_hit_s = (cur_row_s == ROW_LAST) && (cur_col_s == COL_LAST);

    // lb1 holds line y-1; its old contents cascade into lb0 as line y-2.
    sobel_line_buf #(
        .DEPTH (IMG_W),
        .DW    (DW),
        .AW    (CW)
    ) u_lb1 (
        .clk     (clk),
        .we      (done_i),
        .addr    (cur_col_s),
        .wr_data (pix_i),
        .rd_data (lb1_rd_s)
    );

    sobel_line_buf #(
        .DEPTH (IMG_W),
        .DW    (DW),
        .AW    (CW)
    ) u_lb0 (
        .clk     (clk),
        .we      (done_i),
        .addr    (cur_col_s),
        .wr_data (lb1_rd_s),
        .rd_data (lb0_rd_s)
    );

    // Column/row counters advance only on accepted pixels.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_r <= '0;
            row_r <= '0;
        end else if (done_i) begin
            col_r <= nxt_col_s;
            row_r <= nxt_row_s;
        end else begin
            col_r <= col_r;
            row_r <= row_r;
        end
    end

    // Shift each window row left and load the new right column on every pixel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_r[0] <= '0;
            win_r[1] <= '0;
            win_r[2] <= '0;
            win_r[3] <= '0;
            win_r[4] <= '0;
            win_r[5] <= '0;
            win_r[6] <= '0;
            win_r[7] <= '0;
            win_r[8] <= '0;
        end else if (done_i) begin
            win_r[0] <= win_r[1];
            win_r[1] <= win_r[2];
            win_r[2] <= lb0_rd_s;
            win_r[3] <= win_r[4];
            win_r[4] <= win_r[5];
            win_r[5] <= lb1_rd_s;
            win_r[6] <= win_r[7];
            win_r[7] <= win_r[8];
            win_r[8] <= pix_i;
        end else begin
            win_r <= win_r;
        end
    end

    // One-cycle window-valid and end-of-frame strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_r <= 1'b0;
            eof_r  <= 1'b0;
        end else begin
            done_r <= done_i && win_hit_s;
            eof_r  <= done_i && last_hit_s;
        end
    end

    assign d0_o   = win_r[0];
    assign d1_o   = win_r[1];
    assign d2_o   = win_r[2];
    assign d3_o   = win_r[3];
    assign d4_o   = win_r[4];
    assign d5_o   = win_r[5];
    assign d6_o   = win_r[6];
    assign d7_o   = win_r[7];
    assign d8_o   = win_r[8];
    assign done_o = done_r;
    assign eof_o  = eof_r;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen on a 5x4 frame with pixel = base+row*16+col.
module tb_sobel_window_gen;

    localparam int W = 5;
    localparam int H = 4;

    logic       clk;
    logic       rst;
    logic [7:0] pix_i;
    logic       done_i;
    logic       sof_i;
    logic [7:0] d0, d1, d2, d3, d4, d5, d6, d7, d8;
    logic       done_o;
    logic       eof_o;
    logic [71:0] win_s;

    int total;
    int bad;
    int win_cnt;
    logic [71:0] last_exp;
    bit          last_valid;
    logic [7:0]  last_pix;

    sobel_window_gen #(
        .IMG_W (W),
        .IMG_H (H),
        .DW    (8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .pix_i  (pix_i),
        .done_i (done_i),
        .sof_i  (sof_i),
        .d0_o   (d0),
        .d1_o   (d1),
        .d2_o   (d2),
        .d3_o   (d3),
        .d4_o   (d4),
        .d5_o   (d5),
        .d6_o   (d6),
        .d7_o   (d7),
        .d8_o   (d8),
        .done_o (done_o),
        .eof_o  (eof_o)
    );

    assign win_s = {d0, d1, d2, d3, d4, d5, d6, d7, d8};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [71:0] exp_win(input int r, input int c, input logic [7:0] base);
        logic [71:0] w;
        w = '0;
        for (int k = 0; k < 9; k++) begin
            w = {w[63:0], 8'(int'(base) + (r - 2 + k / 3) * 16 + (c - 2 + k % 3))};
        end
        return w;
    endfunction

    task automatic send(input int r, input int c, input bit sof, input logic [7:0] base);
        logic [7:0] p;
        bit ed;
        bit ee;
        p      = 8'(int'(base) + r * 16 + c);
        pix_i  = p;
        done_i = 1'b1;
        sof_i  = sof;
        @(posedge clk);
        #1;
        done_i = 1'b0;
        sof_i  = 1'b0;
        ed = (r >= 2) && (c >= 2);
        ee = (r == H - 1) && (c == W - 1);
        chk("done", {71'd0, done_o}, {71'd0, ed});
        chk("eof", {71'd0, eof_o}, {71'd0, ee});
        if (done_o) win_cnt++;
        if (ed) begin
            last_exp   = exp_win(r, c, base);
            last_valid = 1'b1;
            chk("window", win_s, last_exp);
        end else begin
            last_valid = 1'b0;
        end
        if (ed && r == 2 && c == 2 && base == 8'h00)
            chk("first_win", win_s, 72'h00_01_02_10_11_12_20_21_22);
        if (ee && base == 8'h00)
            chk("eof_d8", {64'd0, d8}, {64'd0, 8'h34});
        last_pix = p;
    endtask

    // Idle cycles with sof_i raised but done_i low: nothing may move.
    task automatic idle(input int n);
        done_i = 1'b0;
        sof_i  = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            chk("idle_done", {71'd0, done_o}, 72'd0);
            chk("idle_eof", {71'd0, eof_o}, 72'd0);
            if (last_valid) chk("idle_win", win_s, last_exp);
            else            chk("idle_d8", {64'd0, d8}, {64'd0, last_pix});
        end
        sof_i = 1'b0;
    endtask

    task automatic frame(input logic [7:0] base, input bit sof, input bit gapped);
        win_cnt = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                send(r, c, sof && r == 0 && c == 0, base);
                if (gapped && ((r * W + c) % 3 == 1)) idle((c % 2) + 1);
            end
        end
        chk("win_count", 72'(win_cnt), 72'd6);
    endtask

    task automatic partial(input logic [7:0] base, input int last_r, input int last_c);
        for (int r = 0; r <= last_r; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r < last_r || c <= last_c) send(r, c, r == 0 && c == 0, base);
            end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        win_cnt = 0;
        last_exp = '0;
        last_valid = 1'b0;
        last_pix = 8'h00;
        rst = 1'b0;
        pix_i = 8'h00;
        done_i = 1'b0;
        sof_i = 1'b0;
        #12;
        chk("rst_win", win_s, 72'd0);
        chk("rst_done", {71'd0, done_o}, 72'd0);
        chk("rst_eof", {71'd0, eof_o}, 72'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Small-frame map, no sof after reset
        frame(8'h00, 1'b0, 1'b0);
        // Second frame with sof and distinct data
        frame(8'h80, 1'b1, 1'b0);
        // Gapped input with ignored sof during gaps
        frame(8'h00, 1'b1, 1'b1);
        // Mid-frame restart: partial frame up to (2,2), sof at (2,3)
        partial(8'h80, 2, 2);
        frame(8'h00, 1'b1, 1'b0);
        // Reset mid-frame at (3,1)
        partial(8'h80, 3, 0);
        rst = 1'b0;
        #1;
        chk("midrst_win", win_s, 72'd0);
        chk("midrst_done", {71'd0, done_o}, 72'd0);
        chk("midrst_eof", {71'd0, eof_o}, 72'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        frame(8'h00, 1'b0, 1'b0);
        // Frame wrap with no sof
        frame(8'h80, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
